// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants for the instruction fetch unit.
//   - FSM state encodings (S_REQ / S_WAIT / S_HOLD)
//   - default reset PC and the sequential PC increment
package instr_fetch_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;  // drive a request to instruction memory
  localparam logic [1:0] S_WAIT = 2'd1;  // request accepted, waiting for the word
  localparam logic [1:0] S_HOLD = 2'd2;  // word presented to the decoder

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory channels and the decoder
// handshake of the fetch unit.
//   imem_req_*   : request channel (valid/ready, byte address, word aligned)
//   imem_resp_*  : response channel (valid + data, no backpressure)
//   instruction, instr_pc, instr_valid / instr_ready : word to the decoder
//   is_jump, is_branch, branch_taken, addr26, imm16  : redirect info back
// master = fetch unit, slave = memory + decoder side.
interface instr_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        is_jump;
  logic        is_branch;
  logic        branch_taken;
  logic [25:0] addr26;
  logic [15:0] imm16;

  modport master (
    output imem_req_valid, imem_req_addr, instruction, instr_pc, instr_valid,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           is_jump, is_branch, branch_taken, addr26, imm16
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instruction, instr_pc, instr_valid,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           is_jump, is_branch, branch_taken, addr26, imm16
  );

endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for the fetch unit.
//   in : instr_pc, is_jump, is_branch, branch_taken, addr26, imm16
//   out: next_pc
// Jump beats branch; all arithmetic wraps modulo 2^32.
module next_pc_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [25:0] addr26,
  input  logic [15:0] imm16,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = instr_pc + PC_INC;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = pc4;
    if (is_jump)                      next_pc = {pc4[31:28], addr26, 2'b00};
    else if (is_branch && branch_taken) next_pc = pc4 + br_off;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: holds the PC, fetches one word at a time from instruction
// memory and presents it with its PC to the decoder.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : instr_fetch_if.master (imem request/response, decoder side)
// Optional build macro INSTR_FETCH_PREFETCH_EN: while a word is held, also
// fetch instr_pc+4 into a one-entry buffer so sequential code can advance
// without a round trip; redirects squash that prefetch.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] next_pc;
  logic [31:0] req_addr;
  logic        req_vld, req_fire, instr_vld, hs;

  next_pc_calc u_npc (
    .instr_pc    (ipc_q),
    .is_jump     (bus.is_jump),
    .is_branch   (bus.is_branch),
    .branch_taken(bus.branch_taken),
    .addr26      (bus.addr26),
    .imm16       (bus.imm16),
    .next_pc     (next_pc)
  );

  // Both valids are masked while rst_n is low so nothing handshakes in the
  // reset cycle.
  assign instr_vld          = rst_n && (state_q == S_HOLD);
  assign hs                 = instr_vld && bus.instr_ready;
  assign bus.imem_req_valid = rst_n && req_vld;
  assign bus.imem_req_addr  = req_addr;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.instr_valid    = instr_vld;
  assign bus.instruction    = instr_q;
  assign bus.instr_pc       = ipc_q;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic        pf_pend_q, pf_pend_d;   // prefetch accepted, word not back yet
  logic        pf_vld_q, pf_vld_d;     // prefetched word in buffer
  logic        squash_q, squash_d;     // drop the next response
  logic [31:0] pf_data_q, pf_data_d;
  logic        redirect, pf_hit;

  assign redirect = bus.is_jump || (bus.is_branch && bus.branch_taken);
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    req_vld  = 1'b0;
    req_addr = pc_q;
`ifdef INSTR_FETCH_PREFETCH_EN
    pf_pend_d = pf_pend_q;
    pf_vld_d  = pf_vld_q;
    pf_data_d = pf_data_q;
    squash_d  = squash_q;
    pf_hit    = 1'b0;
    if (squash_q && bus.imem_resp_valid) squash_d = 1'b0;
`endif
    case (state_q)
      S_REQ: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        // a squashed prefetch still counts as the one outstanding request
        req_vld = !squash_q;
`else
        req_vld = 1'b1;
`endif
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          instr_d = bus.imem_resp_data;
          ipc_d   = pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        req_vld  = !(pf_pend_q || pf_vld_q);
        req_addr = ipc_q + PC_INC;
        pf_hit   = pf_pend_q && bus.imem_resp_valid;
        if (req_fire) pf_pend_d = 1'b1;
        if (pf_hit) begin
          pf_pend_d = 1'b0;
          pf_vld_d  = 1'b1;
          pf_data_d = bus.imem_resp_data;
        end
        if (hs) begin
          pc_d      = next_pc;
          pf_pend_d = 1'b0;
          pf_vld_d  = 1'b0;
          if (redirect) begin
            // a response landing this very cycle is simply not captured
            squash_d = req_fire || (pf_pend_q && !bus.imem_resp_valid);
            state_d  = S_REQ;
          end else if (pf_vld_q || pf_hit) begin
            instr_d = pf_vld_q ? pf_data_q : bus.imem_resp_data;
            ipc_d   = next_pc;
          end else if (pf_pend_q || req_fire) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
`else
        if (hs) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
`endif
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_pend_q <= 1'b0;
      pf_vld_q  <= 1'b0;
      squash_q  <= 1'b0;
      pf_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      pf_pend_q <= pf_pend_d;
      pf_vld_q  <= pf_vld_d;
      squash_q  <= squash_d;
      pf_data_q <= pf_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. Two instances: u_dut with
// the default reset PC and u_dut_j starting at 0x1000_0010 for the jump case.
// Each has a small memory model with programmable latency.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus0();
  instr_fetch_if bus1();

  instr_fetch u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  instr_fetch #(.RESET_PC(32'h1000_0010)) u_dut_j (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;
  int mem_lat = 1;
  int mcnt0 = 0, mcnt1 = 0;
  logic [31:0] madr0, madr1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : {8'hA5, a[23:0]};
  endfunction

  // memory models: observe acceptance at negedge, answer mem_lat cycles later
  always @(negedge clk) begin
    bus0.imem_resp_valid = 1'b0;
    if (mcnt0 > 0) begin
      mcnt0--;
      if (mcnt0 == 0) begin
        bus0.imem_resp_valid = 1'b1;
        bus0.imem_resp_data  = mem_word(madr0);
      end
    end
    if (bus0.imem_req_valid && bus0.imem_req_ready) begin
      chk("one_outstanding", 32'(mcnt0), 32'd0);
      if (mcnt0 == 0) begin
        mcnt0 = mem_lat;
        madr0 = bus0.imem_req_addr;
      end
    end
  end

  always @(negedge clk) begin
    bus1.imem_resp_valid = 1'b0;
    if (mcnt1 > 0) begin
      mcnt1--;
      if (mcnt1 == 0) begin
        bus1.imem_resp_valid = 1'b1;
        bus1.imem_resp_data  = mem_word(madr1);
      end
    end
    if (bus1.imem_req_valid && bus1.imem_req_ready && mcnt1 == 0) begin
      mcnt1 = mem_lat;
      madr1 = bus1.imem_req_addr;
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask
  task automatic cyc(); nxt(); smp(); endtask

  task automatic wait_hold0();
    for (int i = 0; i < 20 && !bus0.instr_valid; i++) cyc();
    chk("hold_wait", 32'(bus0.instr_valid), 32'd1);
  endtask

  task automatic chk_req0(input string tag, input logic [31:0] exp);
    chk({tag, "_v"}, 32'(bus0.imem_req_valid), 32'd1);
    chk(tag, bus0.imem_req_addr, exp);
  endtask

  task automatic clr_dec0();
    bus0.instr_ready = 1'b0; bus0.is_jump = 1'b0; bus0.is_branch = 1'b0;
    bus0.branch_taken = 1'b0; bus0.addr26 = '0; bus0.imm16 = '0;
  endtask

  // one handshake on bus0 with the given redirect inputs; returns sampling
  // in the cycle after the handshake
  task automatic hs0(input logic j, input logic b, input logic t,
                     input logic [25:0] a26, input logic [15:0] i16);
    nxt();
    bus0.instr_ready = 1'b1; bus0.is_jump = j; bus0.is_branch = b;
    bus0.branch_taken = t; bus0.addr26 = a26; bus0.imm16 = i16;
    smp();
    nxt(); clr_dec0(); smp();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_dec0();
    bus0.imem_req_ready = 1'b1;
    bus1.imem_req_ready = 1'b1; bus1.instr_ready = 1'b0; bus1.is_jump = 1'b0;
    bus1.is_branch = 1'b0; bus1.branch_taken = 1'b0; bus1.addr26 = '0; bus1.imm16 = '0;

    repeat (2) @(posedge clk);
    smp();
    chk("rst_req_v",   32'(bus0.imem_req_valid), 32'd0);
    chk("rst_ivld",    32'(bus0.instr_valid), 32'd0);
    chk("rst_instr",   bus0.instruction, 32'd0);
    chk("rst_ipc",     bus0.instr_pc, 32'd0);
    chk("rst_req_v_j", 32'(bus1.imem_req_valid), 32'd0);

    nxt(); rst_n = 1'b1; smp();
    chk_req0("c0_req", 32'h0);
    chk("c0_req_j", bus1.imem_req_addr, 32'h1000_0010);
    cyc();
    chk("c1_ivld", 32'(bus0.instr_valid), 32'd0);
    cyc();
    chk("c2_ivld",  32'(bus0.instr_valid), 32'd1);
    chk("c2_instr", bus0.instruction, 32'h2008_0005);
    chk("c2_ipc",   bus0.instr_pc, 32'h0);
    chk("c2_ipc_j", bus1.instr_pc, 32'h1000_0010);

`ifndef INSTR_FETCH_PREFETCH_EN
    chk("c2_noreq", 32'(bus0.imem_req_valid), 32'd0);
    repeat (5) begin
      cyc();
      chk("bp_ivld",  32'(bus0.instr_valid), 32'd1);
      chk("bp_instr", bus0.instruction, 32'h2008_0005);
      chk("bp_ipc",   bus0.instr_pc, 32'h0);
      chk("bp_noreq", 32'(bus0.imem_req_valid), 32'd0);
    end
    // bus0 sequential, bus1 jump from 0x1000_0010
    nxt();
    bus0.instr_ready = 1'b1;
    bus1.instr_ready = 1'b1; bus1.is_jump = 1'b1; bus1.addr26 = 26'h40;
    smp();
    nxt();
    clr_dec0(); bus1.instr_ready = 1'b0; bus1.is_jump = 1'b0; bus1.addr26 = '0;
    smp();
    chk_req0("seq_req", 32'h4);
    chk("jmp_req", bus1.imem_req_addr, 32'h1000_0100);
    chk("hs_ivld_drop", 32'(bus0.instr_valid), 32'd0);

    wait_hold0();
    chk("pc4_ipc",   bus0.instr_pc, 32'h4);
    chk("pc4_instr", bus0.instruction, 32'hA500_0004);
    hs0(1'b1, 1'b1, 1'b1, 26'h8, 16'h0100);   // jump wins over taken branch
    chk_req0("jmp_prio", 32'h20);
    wait_hold0();
    chk("at20_ipc", bus0.instr_pc, 32'h20);
    hs0(1'b0, 1'b1, 1'b1, 26'h0, 16'hFFFE);
    chk_req0("br_taken", 32'h1C);
    wait_hold0();
    // redirect inputs without instr_ready must be ignored
    nxt(); bus0.is_jump = 1'b1; bus0.addr26 = 26'h3F; smp();
    chk("no_hs_hold", 32'(bus0.instr_valid), 32'd1);
    hs0(1'b0, 1'b0, 1'b0, 26'h0, 16'h0);
    chk_req0("seq_after_br", 32'h20);
    wait_hold0();
    hs0(1'b0, 1'b1, 1'b0, 26'h0, 16'hFFFE);
    chk_req0("br_not_taken", 32'h24);
    wait_hold0();
    hs0(1'b0, 1'b1, 1'b1, 26'h0, 16'hFFF5);
    chk_req0("br_wrap_tgt", 32'hFFFF_FFFC);
    wait_hold0();
    chk("top_ipc",   bus0.instr_pc, 32'hFFFF_FFFC);
    chk("top_instr", bus0.instruction, 32'hA5FF_FFFC);
    hs0(1'b0, 1'b0, 1'b0, 26'h0, 16'h0);
    chk_req0("pc4_wrap", 32'h0);

    // request stall, then reset while waiting on a slow response
    wait_hold0();
    nxt(); bus0.imem_req_ready = 1'b0; bus0.instr_ready = 1'b1; smp();
    nxt(); bus0.instr_ready = 1'b0; smp();
    repeat (3) begin
      chk_req0("stall_req", 32'h4);
      cyc();
    end
    nxt(); mem_lat = 3; bus0.imem_req_ready = 1'b1; smp();
    nxt(); bus0.imem_req_ready = 1'b0; smp();
    chk("wait_ivld", 32'(bus0.instr_valid), 32'd0);
    nxt(); rst_n = 1'b0; smp();
    chk("mid_rst_req_v", 32'(bus0.imem_req_valid), 32'd0);
    nxt(); rst_n = 1'b1; smp();
    chk_req0("post_rst_req", 32'h0);
    cyc();
    chk("stale_ivld", 32'(bus0.instr_valid), 32'd0);
    chk_req0("post_rst_req2", 32'h0);
    nxt(); bus0.imem_req_ready = 1'b1; mem_lat = 1; smp();
    wait_hold0();
    chk("post_rst_instr", bus0.instruction, 32'h2008_0005);
    chk("post_rst_ipc",   bus0.instr_pc, 32'h0);
`else
    repeat (3) cyc();
    nxt(); bus0.instr_ready = 1'b1; smp();
    chk("pf_first_ipc", bus0.instr_pc, 32'h0);
    cyc();
    chk("pf_b2b_ivld",  32'(bus0.instr_valid), 32'd1);
    chk("pf_b2b_ipc",   bus0.instr_pc, 32'h4);
    chk("pf_b2b_instr", bus0.instruction, 32'hA500_0004);
    for (int k = 2; k < 4; k++) begin
      cyc();
      for (int i = 0; i < 10 && !bus0.instr_valid; i++) cyc();
      chk("pf_seq_ipc",   bus0.instr_pc, 32'(4 * k));
      chk("pf_seq_instr", bus0.instruction, mem_word(32'(4 * k)));
    end
    nxt(); bus0.instr_ready = 1'b0; mem_lat = 3; smp();
    wait_hold0();
    repeat (6) cyc();
    chk("pf_at10_ipc", bus0.instr_pc, 32'h10);
    nxt(); bus0.instr_ready = 1'b1; smp();
    nxt(); bus0.is_jump = 1'b1; bus0.addr26 = 26'h20; smp();
    chk("pf_buf_ipc", bus0.instr_pc, 32'h14);
    nxt(); clr_dec0(); smp();
    wait_hold0();
    chk("pf_jmp_ipc",   bus0.instr_pc, 32'h80);
    chk("pf_jmp_instr", bus0.instruction, 32'hA500_0080);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer side of the 32-bit instruction interface consumed by the control decoder.
- Holds the PC and issues single-word requests to instruction memory over a valid/ready request channel plus a response channel.
- Presents each fetched word with its PC to the decoder over a valid/ready handshake.
- Takes the decoder's is_jump, is_branch, addr26 and imm16 outputs, plus an externally resolved branch_taken, and computes the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req_valid  out  1  request address valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address of the request (byte address, bits [1:0]=0).
- imem_resp_valid  in  1  response data valid; arrives at least 1 cycle after request acceptance.
- imem_resp_data  in  32  fetched word.
- instruction  out  32  word presented to the decoder.
- instr_pc  out  32  PC of the presented word.
- instr_valid  out  1  instruction/instr_pc valid.
- instr_ready  in  1  decoder consumes the word.
- is_jump  in  1  from decoder, qualified by the instruction handshake.
- is_branch  in  1  from decoder, qualified by the instruction handshake.
- branch_taken  in  1  branch condition result, qualified by the instruction handshake.
- addr26  in  26  jump field.
- imm16  in  16  branch offset field.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, state=S_REQ.
  - instr_valid=0, imem_req_valid=0 in the reset cycle; instruction=0, instr_pc=0.
  - Reset mid-transaction abandons it; any later response is ignored until a new request is accepted.
- States:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. Address is held stable while valid && !ready. On imem_req_ready go to S_WAIT.
  - S_WAIT: on imem_resp_valid, register instruction<=imem_resp_data and instr_pc<=pc, then go to S_HOLD.
  - S_HOLD: instr_valid=1, with instruction and instr_pc stable until the handshake. On instr_valid && instr_ready, pc<=next_pc and go to S_REQ.
- next_pc:
  - pc4 = instr_pc + 4.
  - Jump: is_jump=1 -> {pc4[31:28], addr26, 2'b00}.
  - Taken branch: is_branch && branch_taken -> pc4 + (sign_ext(imm16) << 2).
  - Otherwise pc4.
  - is_jump has priority over is_branch.
- Arithmetic is 32-bit modulo: pc4 at 0xFFFF_FFFC wraps to 0; branch targets wrap the same way.
- Redirect inputs are sampled only in the handshake cycle and ignored otherwise.
- imem_resp_valid outside S_WAIT is ignored (non-prefetch build).
- Exactly one request outstanding.
- Latency, with ready tied high and a 1-cycle memory:
  - request accepted in cycle 0, response in cycle 1, instr_valid in cycle 2.
  - Throughput is 1 instruction per 3 cycles.

Optional Feature:
- Macro: INSTR_FETCH_PREFETCH_EN.
- Defined:
  - In S_HOLD, also issue a request for instr_pc+4.
  - Capture its response in a one-entry prefetch buffer with a valid bit.
  - On handshake with sequential next_pc: if the buffer is valid, load it directly and stay in S_HOLD, giving back-to-back instructions. If the request is still outstanding, go to S_WAIT. If it was never accepted, go to S_REQ.
  - On handshake with a redirect: clear the buffer; if the prefetch is still outstanding, set a squash flag and drop its response; then request the target.
  - Still at most one outstanding request.
- Undefined: behaviour exactly as above; no buffer, no squash logic.

Decomposition:
- Shared constants in _const.v:
  - state encodings S_REQ/S_WAIT/S_HOLD;
  - default RESET_PC;
  - PC increment 4.
- One combinational sub-module, next_pc_calc: inputs instr_pc, is_jump, is_branch, branch_taken, addr26, imm16; output next_pc.

Test Plan:
- Reset, ready always 1, 1-cycle memory returning 0x2008_0005 -> imem_req_addr=0x0 in cycle 0; instr_valid=1 in cycle 2 with instruction=0x2008_0005, instr_pc=0x0; next request addr 0x4.
- Decoder backpressure: instr_ready=0 for 5 cycles -> instruction/instr_pc stable, no new request; handshake -> request 0x4.
- Jump at instr_pc=0x1000_0010, addr26=0x000_0040 -> next request 0x1000_0100.
- Branch at instr_pc=0x20, imm16=0xFFFE: branch_taken=1 -> 0x1C; branch_taken=0 -> 0x24.
- imem_req_ready low 3 cycles and rst_n pulsed during S_WAIT -> addr stable while stalled; after reset, request 0x0 and the stale response is ignored.
- (INSTR_FETCH_PREFETCH_EN) sequential stream, ready high -> one instruction per cycle after the first. Jump while a prefetch is outstanding -> prefetched word never appears on instruction; next instr_pc equals the target.
